seg_scan_controller: RTL and testbench

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_scan_controller.sv | 83 ++++++++
 tb/tb_seg_scan_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Eight-digit seven-segment scan controller: digit register file, dwell timer
// and enable-mask-aware digit rotation feeding an external hex decoder.
module seg_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [7:0] digit_en,
  output logic [3:0] c,
  output logic [2:0] s,
  output logic       dpoint,
  output logic       blank,
  output logic       frame_tick
);

  localparam logic [23:0] LAST = 24'(REFRESH_DIV - 1);

  logic [3:0]  val [8];
  logic [7:0]  dps;
  logic [23:0] cnt, cnt_next;
  logic [2:0]  nxt, idx, s_next;
  logic        found, any_en, advance, wrap, c_byp;
  logic [3:0]  c_next;
  logic        dp_next;

  // Nearest enabled index above s (mod 8); stays on s when no other is enabled.
  always_comb begin
    nxt   = s;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k < 8; k++) begin
      idx = s + 3'(k);
      if (!found && digit_en[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    any_en   = |digit_en;
    advance  = any_en && ((cnt == LAST) || !digit_en[s]);
    s_next   = advance ? nxt : s;
    wrap     = advance && (nxt <= s);
    cnt_next = (!any_en || advance) ? '0 : cnt + 24'd1;
    c_byp    = wr_en && (wr_addr == s_next);
    c_next   = c_byp ? wr_data : val[s_next];
    dp_next  = c_byp ? wr_dp : dps[s_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) val[i] <= '0;
      dps <= '0;
    end else if (wr_en) begin
      val[wr_addr] <= wr_data;
      dps[wr_addr] <= wr_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      s          <= '0;
      c          <= '0;
      dpoint     <= 1'b0;
      blank      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      s          <= s_next;
      c          <= c_next;
      dpoint     <= dp_next;
      blank      <= !any_en;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with REFRESH_DIV=4: a per-cycle vector
// table plus hand-written reset and post-reset sequences.
module tb_seg_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic [7:0] digit_en = 8'hFF;
  logic [3:0] c;
  logic [2:0] s;
  logic       dpoint, blank, frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_controller #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .digit_en(digit_en),
    .c(c), .s(s), .dpoint(dpoint), .blank(blank), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         hold;
    logic       we;
    logic [2:0] a;
    logic [3:0] d;
    logic       dp;
    logic [7:0] en;
    logic [2:0] es;
    logic [3:0] ec;
    logic       edp;
    logic       eblank;
    logic       eft;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int hold, logic we, logic [2:0] a, logic [3:0] d,
                              logic dp, logic [7:0] en, logic [2:0] es,
                              logic [3:0] ec, logic edp, logic eblank, logic eft);
    vec_t v;
    v.hold = hold; v.we = we; v.a = a; v.d = d; v.dp = dp; v.en = en;
    v.es = es; v.ec = ec; v.edp = edp; v.eblank = eblank; v.eft = eft;
    return v;
  endfunction

  // Packed as {s, c, dpoint, blank, frame_tick}
  task automatic chk(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {s, c, dpoint, blank, frame_tick};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got s=%0d c=%h dp=%b blank=%b ft=%b, want s=%0d c=%h dp=%b blank=%b ft=%b",
               name, act[9:7], act[6:3], act[2], act[1], act[0],
               exp[9:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // hold, we, addr, data, dp, en, | s, c, dp, blank, ft
    tbl.push_back(mk(1, 1, 0, 4'h1, 0, 8'hFF, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h2, 0, 8'hFF, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 4'h3, 0, 8'hFF, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 4'h4, 0, 8'hFF, 1, 4'h2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4, 4'h5, 0, 8'hFF, 1, 4'h2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 4'h6, 0, 8'hFF, 1, 4'h2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6, 4'h7, 0, 8'hFF, 1, 4'h2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 7, 4'h8, 0, 8'hFF, 2, 4'h3, 0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'hFF, 2, 4'h3, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'hFF, 3, 4'h4, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'hFF, 4, 4'h5, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'hFF, 5, 4'h6, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'hFF, 6, 4'h7, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'hFF, 7, 4'h8, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'hFF, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'hFF, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'hFF, 1, 4'h2, 0, 0, 0));
    // sparse mask 0010_0101; s=1 is disabled so the first edge skips to 2
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'h25, 2, 4'h3, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'h25, 5, 4'h6, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h25, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'h25, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'h25, 2, 4'h3, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'h25, 5, 4'h6, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h25, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'h25, 0, 4'h1, 0, 0, 0));
    // write to the displayed digit 3 mid-dwell
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'hFF, 1, 4'h2, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4'h0, 0, 8'hFF, 2, 4'h3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'hFF, 3, 4'h4, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 4'hA, 1, 8'hFF, 3, 4'hA, 1, 0, 0));
    tbl.push_back(mk(2, 0, 0, 4'h0, 0, 8'hFF, 3, 4'hA, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'hFF, 4, 4'h5, 0, 0, 0));
    // disabling the current digit forces an immediate advance
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h84, 7, 4'h8, 0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'h84, 7, 4'h8, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h84, 2, 4'h3, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h80, 7, 4'h8, 0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'h80, 7, 4'h8, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h80, 7, 4'h8, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'h00, 7, 4'h8, 0, 1, 0));
    // single-digit mask re-selects digit 0 every dwell
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h01, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'h01, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h01, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 4'h0, 0, 8'h01, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h01, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h80, 7, 4'h8, 0, 0, 0));

    // reset values while held
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int h = 0; h < tbl[i].hold; h++) begin
        wr_en = tbl[i].we; wr_addr = tbl[i].a; wr_data = tbl[i].d;
        wr_dp = tbl[i].dp; digit_en = tbl[i].en;
        @(posedge clk);
        #1 chk($sformatf("vec%0d.%0d", i, h),
               {tbl[i].es, tbl[i].ec, tbl[i].edp, tbl[i].eblank, tbl[i].eft});
        @(negedge clk);
      end
    end

    // asynchronous reset mid-dwell with a write pending
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hF; wr_dp = 1'b1; digit_en = 8'hFF;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 10'b0);
    @(posedge clk);
    #1 chk("reset_write_dropped", 10'b0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;

    // every entry reads back as zero; first advance 4 cycles after release
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1 chk($sformatf("post_reset%0d", k),
             {3'((k / 4) % 8), 4'h0, 1'b0, 1'b0, (k == 32)});
      @(negedge clk);
    end

    // write to the displayed digit lands on the next edge
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9; wr_dp = 1'b1;
    @(posedge clk);
    #1 chk("bypass_write", {3'd0, 4'h9, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    wr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
